// File: rtl/axi_slv_mem_resp.sv
// AXI4 slave memory endpoint: one outstanding write (AW/W/B) and one outstanding
// read (AR/R), running independently over a word-addressed register array.
module axi_slv_mem_resp #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MEM_WORDS      = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user,
    input  logic [5:0]                  aw_atop,
    input  logic                        aw_lock,
    input  logic [3:0]                  aw_cache,
    input  logic [2:0]                  aw_prot,
    input  logic [3:0]                  aw_qos,
    input  logic [3:0]                  aw_region,
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic [AXI_USER_WIDTH-1:0]   w_user,
    input  logic                        w_valid,
    output logic                        w_ready,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                  b_resp,
    output logic [AXI_USER_WIDTH-1:0]   b_user,
    output logic                        b_valid,
    input  logic                        b_ready,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user,
    input  logic                        ar_lock,
    input  logic [3:0]                  ar_cache,
    input  logic [2:0]                  ar_prot,
    input  logic [3:0]                  ar_qos,
    input  logic [3:0]                  ar_region,
    input  logic                        ar_valid,
    output logic                        ar_ready,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_USER_WIDTH-1:0]   r_user,
    output logic                        r_valid,
    input  logic                        r_ready
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int OFS    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);

    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic addr_t next_addr(input addr_t addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        addr_t step;
        addr_t span;
        addr_t res;
        step = addr_t'(1) << size;
        span = (addr_t'(len) + addr_t'(1)) << size;
        case (burst)
            2'd0:    res = addr;
            2'd1:    res = addr + step;
            2'd2:    res = (addr & ~(span - addr_t'(1))) | ((addr + step) & (span - addr_t'(1)));
            default: res = addr;
        endcase
        return res;
    endfunction

    // Conditions that poison an entire burst, fixed at address-phase time.
    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input logic [5:0] atop);
        logic wrap_len_bad;
        wrap_len_bad = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (size > 3'(OFS)) || (burst == 2'd3) || ((burst == 2'd2) && wrap_len_bad) ||
               (atop != 6'd0);
    endfunction

    function automatic logic idx_oob(input addr_t addr);
        return (addr >> OFS) >= addr_t'(MEM_WORDS);
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem_r [MEM_WORDS];

    w_state_t                  w_state_r, w_state_s;
    addr_t                     w_addr_r;
    logic [7:0]                w_len_r, w_cnt_r;
    logic [2:0]                w_size_r;
    logic [1:0]                w_burst_r, b_resp_r;
    logic                      w_bad_r, w_err_r, aw_ready_r;
    logic [AXI_ID_WIDTH-1:0]   b_id_r;
    logic [AXI_USER_WIDTH-1:0] b_user_r;
    logic                      w_hs_s, w_last_exp_s, w_oob_s, w_beat_err_s, mem_we_s;
    logic [IDX_W-1:0]          w_idx_s;

    r_state_t                  r_state_r, r_state_s;
    addr_t                     r_addr_r;
    logic [7:0]                r_len_r, r_cnt_r;
    logic [2:0]                r_size_r;
    logic [1:0]                r_burst_r;
    logic                      r_bad_r, ar_ready_r;
    logic [AXI_ID_WIDTH-1:0]   r_id_r;
    logic [AXI_USER_WIDTH-1:0] r_user_r;
    logic                      r_valid_s, r_last_s, r_err_s;
    logic [IDX_W-1:0]          r_idx_s;

    logic unused_s;
    assign unused_s = ^{aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
                        ar_lock, ar_cache, ar_prot, ar_qos, ar_region, w_user};

    assign w_hs_s       = (w_state_r == W_DATA) && w_valid;
    assign w_last_exp_s = (w_cnt_r == w_len_r);
    assign w_oob_s      = idx_oob(w_addr_r);
    assign w_idx_s      = w_addr_r[OFS +: IDX_W];
    assign w_beat_err_s = w_oob_s || (w_last != w_last_exp_s);
    assign mem_we_s     = w_hs_s && !w_bad_r && !w_oob_s;

    assign aw_ready = aw_ready_r;
    assign w_ready  = (w_state_r == W_DATA);
    assign b_valid  = (w_state_r == W_RESP);
    assign b_id     = b_id_r;
    assign b_resp   = b_resp_r;
    assign b_user   = b_user_r;

    // Write FSM next state.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_valid && aw_ready_r) w_state_s = W_DATA;
                else                        w_state_s = W_IDLE;
            end
            W_DATA: begin
                if (w_valid && w_last_exp_s) w_state_s = W_RESP;
                else                         w_state_s = W_DATA;
            end
            W_RESP: begin
                if (b_ready) w_state_s = W_IDLE;
                else         w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write channel state, burst tracking and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r  <= W_IDLE;
            aw_ready_r <= 1'b0;
            w_addr_r   <= '0;
            w_len_r    <= 8'd0;
            w_cnt_r    <= 8'd0;
            w_size_r   <= 3'd0;
            w_burst_r  <= 2'd0;
            w_bad_r    <= 1'b0;
            w_err_r    <= 1'b0;
            b_resp_r   <= 2'd0;
            b_id_r     <= '0;
            b_user_r   <= '0;
        end else begin
            w_state_r  <= w_state_s;
            aw_ready_r <= (w_state_s == W_IDLE);
            if ((w_state_r == W_IDLE) && aw_valid && aw_ready_r) begin
                w_addr_r  <= aw_addr;
                w_len_r   <= aw_len;
                w_cnt_r   <= 8'd0;
                w_size_r  <= aw_size;
                w_burst_r <= aw_burst;
                w_bad_r   <= burst_bad(aw_len, aw_size, aw_burst, aw_atop);
                w_err_r   <= burst_bad(aw_len, aw_size, aw_burst, aw_atop);
                b_id_r    <= aw_id;
                b_user_r  <= aw_user;
            end else if (w_hs_s) begin
                w_addr_r <= next_addr(w_addr_r, w_len_r, w_size_r, w_burst_r);
                w_cnt_r  <= w_cnt_r + 8'd1;
                w_err_r  <= w_err_r | w_beat_err_s;
                if (w_last_exp_s) b_resp_r <= (w_err_r | w_beat_err_s) ? 2'b10 : 2'b00;
            end
        end
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) mem_r[w_idx_s][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    assign r_valid_s = (r_state_r == R_DATA);
    assign r_last_s  = r_valid_s && (r_cnt_r == r_len_r);
    assign r_idx_s   = r_addr_r[OFS +: IDX_W];
    assign r_err_s   = r_bad_r || idx_oob(r_addr_r);

    assign ar_ready = ar_ready_r;
    assign r_valid  = r_valid_s;
    assign r_last   = r_last_s;
    assign r_id     = r_id_r;
    assign r_user   = r_user_r;
    assign r_data   = (r_valid_s && !r_err_s) ? mem_r[r_idx_s] : '0;
    assign r_resp   = (r_valid_s && r_err_s) ? 2'b10 : 2'b00;

    // Read FSM next state.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_valid && ar_ready_r) r_state_s = R_DATA;
                else                        r_state_s = R_IDLE;
            end
            R_DATA: begin
                if (r_ready && r_last_s) r_state_s = R_IDLE;
                else                     r_state_s = R_DATA;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read channel state and burst address tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r  <= R_IDLE;
            ar_ready_r <= 1'b0;
            r_addr_r   <= '0;
            r_len_r    <= 8'd0;
            r_cnt_r    <= 8'd0;
            r_size_r   <= 3'd0;
            r_burst_r  <= 2'd0;
            r_bad_r    <= 1'b0;
            r_id_r     <= '0;
            r_user_r   <= '0;
        end else begin
            r_state_r  <= r_state_s;
            ar_ready_r <= (r_state_s == R_IDLE);
            if ((r_state_r == R_IDLE) && ar_valid && ar_ready_r) begin
                r_addr_r  <= ar_addr;
                r_len_r   <= ar_len;
                r_cnt_r   <= 8'd0;
                r_size_r  <= ar_size;
                r_burst_r <= ar_burst;
                r_bad_r   <= burst_bad(ar_len, ar_size, ar_burst, 6'd0);
                r_id_r    <= ar_id;
                r_user_r  <= ar_user;
            end else if (r_valid_s && r_ready) begin
                r_addr_r <= next_addr(r_addr_r, r_len_r, r_size_r, r_burst_r);
                r_cnt_r  <= r_cnt_r + 8'd1;
            end
        end
    end

endmodule
